fifo_bus_sel_arbiter: RTL and testbench

- Per-FIFO write arbiter for the fd-to-FIFO bus-select crossbar.
- One instance per destination FIFO. Its request vector is that FIFO's bus-select vector, where bit x means frame source fd_x is selecting this FIFO.
- Grants exactly one source at a time, round-robin. Holds the grant for a whole packet and gates the FIFO write enable.
- Full FIFO produces backpressure; an optional watchdog releases stalled grants.

---
 rtl/fifo_bus_sel_arbiter.sv | 148 ++++++++++++++
 tb/tb_fifo_bus_sel_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_bus_sel_arbiter.sv
// rtl/fifo_bus_sel_arbiter.sv - round-robin per-FIFO write arbiter, packet-held grant, optional watchdog (FIFO_BUS_SEL_ARB_TIMEOUT_EN)
module fifo_bus_sel_arbiter #(
    parameter int PORT_NUM    = 4,
    parameter int IDX_W       = 2,
    parameter int TIMEOUT_CYC = 1023,
    parameter int TO_W        = 10
) (
    input  logic                clk,
    input  logic                rst,          // synchronous, active-high
    input  logic [PORT_NUM-1:0] bus_sel,      // bit x: fd_x selects this FIFO
    input  logic [PORT_NUM-1:0] pkt_vld,      // per-source data valid
    input  logic [PORT_NUM-1:0] pkt_last,     // per-source last word, qualified by pkt_vld
    input  logic                fifo_full,    // destination FIFO full
    output logic [PORT_NUM-1:0] grant,        // one-hot grant
    output logic                grant_vld,    // any grant active
    output logic [IDX_W-1:0]    grant_idx,    // binary index of granted source
    output logic                fifo_wr_en,   // FIFO write enable
    output logic                pkt_done,     // pulse: packet ended with accepted last
    output logic                abort_err,    // pulse: granted source dropped request early
    output logic                timeout_err   // pulse: watchdog forced release
);

    typedef enum logic {IDLE, BUSY} state_e;

    if (TIMEOUT_CYC >= (1 << TO_W) || (1 << IDX_W) < PORT_NUM) begin : g_param_check
        $error("fifo_bus_sel_arbiter: inconsistent TIMEOUT_CYC/TO_W or IDX_W/PORT_NUM");
    end

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      ptr_q, ptr_d;
    logic [IDX_W-1:0]      grant_idx_q, grant_idx_d;
    logic [PORT_NUM-1:0]   grant_q, grant_d;
    logic                  grant_vld_q, grant_vld_d;
    logic                  pkt_done_q, pkt_done_d;
    logic                  abort_err_q, abort_err_d;
    logic                  timeout_err_q, timeout_err_d;
    logic                  sel_found;
    logic [IDX_W-1:0]      sel_idx;
    logic                  timeout_hit;

    assign grant       = grant_q;
    assign grant_vld   = grant_vld_q;
    assign grant_idx   = grant_idx_q;
    assign pkt_done    = pkt_done_q;
    assign abort_err   = abort_err_q;
    assign timeout_err = timeout_err_q;
    assign fifo_wr_en  = grant_vld_q & pkt_vld[grant_idx_q] & ~fifo_full;

    // Round-robin search starting one past the last released source.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = 1; i <= PORT_NUM; i++) begin
            if (!sel_found && bus_sel[(int'(ptr_q) + i) % PORT_NUM]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'((int'(ptr_q) + i) % PORT_NUM);
            end
        end
    end

`ifdef FIFO_BUS_SEL_ARB_TIMEOUT_EN
    logic [TO_W-1:0] wd_cnt_q, wd_cnt_d;

    // Held at zero while idle so a fresh grant always starts from zero;
    // any accepted write proves the source is alive.
    always_comb begin
        wd_cnt_d = wd_cnt_q;
        if (state_q == IDLE || fifo_wr_en) begin
            wd_cnt_d = '0;
        end else begin
            wd_cnt_d = wd_cnt_q + TO_W'(1);
        end
    end

    assign timeout_hit = (state_q == BUSY) && (wd_cnt_q == TO_W'(TIMEOUT_CYC));

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt_q <= '0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        grant_d       = grant_q;
        grant_vld_d   = grant_vld_q;
        grant_idx_d   = grant_idx_q;
        pkt_done_d    = 1'b0;
        abort_err_d   = 1'b0;
        timeout_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (sel_found && !fifo_full) begin
                    grant_d     = {{(PORT_NUM-1){1'b0}}, 1'b1} << sel_idx;
                    grant_vld_d = 1'b1;
                    grant_idx_d = sel_idx;
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                // Release priority: accepted last, then dropped request, then watchdog.
                if ((fifo_wr_en && pkt_last[grant_idx_q]) || !bus_sel[grant_idx_q] || timeout_hit) begin
                    grant_d     = '0;
                    grant_vld_d = 1'b0;
                    ptr_d       = grant_idx_q;
                    state_d     = IDLE;
                    if (fifo_wr_en && pkt_last[grant_idx_q]) begin
                        pkt_done_d = 1'b1;
                    end else if (!bus_sel[grant_idx_q]) begin
                        abort_err_d = 1'b1;
                    end else begin
                        timeout_err_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            ptr_q         <= IDX_W'(PORT_NUM - 1);
            grant_q       <= '0;
            grant_vld_q   <= 1'b0;
            grant_idx_q   <= '0;
            pkt_done_q    <= 1'b0;
            abort_err_q   <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            grant_q       <= grant_d;
            grant_vld_q   <= grant_vld_d;
            grant_idx_q   <= grant_idx_d;
            pkt_done_q    <= pkt_done_d;
            abort_err_q   <= abort_err_d;
            timeout_err_q <= timeout_err_d;
        end
    end

endmodule

// File: tb/tb_fifo_bus_sel_arbiter.sv
// tb/tb_fifo_bus_sel_arbiter.sv - scoreboard bench for fifo_bus_sel_arbiter
module tb_fifo_bus_sel_arbiter;

    localparam int PORT_NUM = 4;
    localparam int IDX_W    = 2;
    localparam int TO_CYC   = 8;
    localparam int TO_W     = 10;
`ifdef FIFO_BUS_SEL_ARB_TIMEOUT_EN
    localparam int FULL_CYC = 5;
`else
    localparam int FULL_CYC = 10;
`endif

    localparam int EV_DONE  = 1;
    localparam int EV_ABORT = 2;
    localparam int EV_TO    = 4;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [PORT_NUM-1:0] bus_sel  = '0;
    logic [PORT_NUM-1:0] pkt_vld  = '0;
    logic [PORT_NUM-1:0] pkt_last = '0;
    logic                fifo_full = 1'b0;
    logic [PORT_NUM-1:0] grant;
    logic                grant_vld;
    logic [IDX_W-1:0]    grant_idx;
    logic                fifo_wr_en;
    logic                pkt_done;
    logic                abort_err;
    logic                timeout_err;

    int n_checks = 0;
    int n_errors = 0;
    int wr_cnt   = 0;
    int exp_grant[$];
    int exp_evt[$];
    logic prev_vld = 1'b0;
    int mon_e;
    int wr_base;
    int cyc;

    fifo_bus_sel_arbiter #(
        .PORT_NUM(PORT_NUM), .IDX_W(IDX_W), .TIMEOUT_CYC(TO_CYC), .TO_W(TO_W)
    ) dut (
        .clk(clk), .rst(rst), .bus_sel(bus_sel), .pkt_vld(pkt_vld), .pkt_last(pkt_last),
        .fifo_full(fifo_full), .grant(grant), .grant_vld(grant_vld), .grant_idx(grant_idx),
        .fifo_wr_en(fifo_wr_en), .pkt_done(pkt_done), .abort_err(abort_err),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(input int budget);
        int n;
        n = 0;
        while (!grant_vld && n < budget) begin
            step();
            n++;
        end
        if (!grant_vld) check("wait_grant_budget", 32'(grant_vld), 32'd1);
    endtask

    // Scoreboard side: grants and release pulses are popped as the DUT shows them.
    always @(negedge clk) begin
        if (fifo_wr_en) wr_cnt++;
        if (!rst && grant_vld && !prev_vld) begin
            if (exp_grant.size() == 0) begin
                check("grant_unexpected", 32'(grant_idx), 32'hffff_ffff);
            end else begin
                mon_e = exp_grant.pop_front();
                check("sb_grant_idx", 32'(grant_idx), 32'(mon_e));
                check("sb_grant_onehot", 32'(grant), 32'(1) << mon_e);
            end
        end
        if (pkt_done || abort_err || timeout_err) begin
            if (exp_evt.size() == 0) begin
                check("evt_unexpected", {29'd0, timeout_err, abort_err, pkt_done}, 32'd0);
            end else begin
                mon_e = exp_evt.pop_front();
                check("sb_event", {29'd0, timeout_err, abort_err, pkt_done}, 32'(mon_e));
            end
        end
        prev_vld = grant_vld;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

    initial begin
        // Reset state
        repeat (3) step();
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_grant_vld", 32'(grant_vld), 32'd0);
        check("rst_grant_idx", 32'(grant_idx), 32'd0);
        check("rst_pulses", {29'd0, timeout_err, abort_err, pkt_done}, 32'd0);
        rst = 1'b0;
        step();

        // Three-word packet from source 1, 0110 request set, ptr=3
        bus_sel = 4'b0110;
        exp_grant.push_back(1);
        step();
        check("t1_grant", 32'(grant), 32'b0010);
        check("t1_grant_idx", 32'(grant_idx), 32'd1);
        wr_base = wr_cnt;
        pkt_vld = 4'b0010;
        step();
        step();
        pkt_last = 4'b0010;
        exp_evt.push_back(EV_DONE);
        step();
        bus_sel = '0; pkt_vld = '0; pkt_last = '0;
        check("t1_pkt_done", 32'(pkt_done), 32'd1);
        check("t1_released", 32'(grant), 32'd0);
        check("t1_writes", 32'(wr_cnt - wr_base), 32'd3);

        // Fairness after reset: 0,1,2,3,0 with one idle cycle between grants
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus_sel = 4'b1111; pkt_vld = 4'b1111; pkt_last = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp_grant.push_back(k % PORT_NUM);
            exp_evt.push_back(EV_DONE);
        end
        for (int k = 0; k < 5; k++) begin
            wait_grant(4);
            check("t2_order", 32'(grant_idx), 32'(k % PORT_NUM));
            step();
            if (k == 4) begin
                bus_sel = '0; pkt_vld = '0; pkt_last = '0;
            end
            check("t2_gap", 32'(grant_vld), 32'd0);
        end
        step();

        // Backpressure mid-packet on source 2
        bus_sel = 4'b0100; pkt_vld = 4'b0100;
        exp_grant.push_back(2);
        exp_evt.push_back(EV_DONE);
        step();
        wr_base = wr_cnt;
        step();
        fifo_full = 1'b1;
        for (int k = 0; k < FULL_CYC; k++) begin
            step();
            check("t3_held", 32'(grant), 32'b0100);
            check("t3_no_wr", 32'(fifo_wr_en), 32'd0);
        end
        fifo_full = 1'b0;
        pkt_last = 4'b0100;
        step();
        bus_sel = '0; pkt_vld = '0; pkt_last = '0;
        check("t3_pkt_done", 32'(pkt_done), 32'd1);
        check("t3_writes", 32'(wr_cnt - wr_base), 32'd2);

        // Abort from source 3, then 1001 goes to source 0
        bus_sel = 4'b1000; pkt_vld = 4'b1000;
        exp_grant.push_back(3);
        step();
        check("t4_grant", 32'(grant), 32'b1000);
        step();
        bus_sel = '0; pkt_vld = '0;
        exp_evt.push_back(EV_ABORT);
        step();
        check("t4_abort", 32'(abort_err), 32'd1);
        check("t4_released", 32'(grant_vld), 32'd0);
        bus_sel = 4'b1001;
        exp_grant.push_back(0);
        step();
        check("t4_regrant", 32'(grant), 32'b0001);
        pkt_vld = 4'b0001; pkt_last = 4'b0001;
        exp_evt.push_back(EV_DONE);
        step();
        bus_sel = '0; pkt_vld = '0; pkt_last = '0;
        check("t4_abort_cleared", 32'(abort_err), 32'd0);

        // Reset mid-packet on source 1
        bus_sel = 4'b0010; pkt_vld = 4'b0010;
        exp_grant.push_back(1);
        step();
        step();
        rst = 1'b1;
        step();
        check("t5_rst_grant", 32'(grant), 32'd0);
        check("t5_rst_vld", 32'(grant_vld), 32'd0);
        check("t5_rst_idx", 32'(grant_idx), 32'd0);
        rst = 1'b0;
        bus_sel = 4'b1010; pkt_vld = '0;
        exp_grant.push_back(1);
        step();
        check("t5_after_rst", 32'(grant), 32'b0010);
        pkt_vld = 4'b0010; pkt_last = 4'b0010;
        exp_evt.push_back(EV_DONE);
        step();
        bus_sel = '0; pkt_vld = '0; pkt_last = '0;

        // Stalled source 0 (never valid)
        bus_sel = 4'b0011;
        exp_grant.push_back(0);
        step();
        check("t6_grant0", 32'(grant), 32'b0001);
`ifdef FIFO_BUS_SEL_ARB_TIMEOUT_EN
        exp_evt.push_back(EV_TO);
        exp_grant.push_back(1);
        cyc = 0;
        while (!timeout_err && cyc < 40) begin
            step();
            cyc++;
        end
        check("t6_timeout_seen", 32'(timeout_err), 32'd1);
        check("t6_timeout_cycles", 32'(cyc), 32'(TO_CYC + 1));
        wait_grant(4);
        check("t6_next_grant", 32'(grant), 32'b0010);
        pkt_vld = 4'b0010; pkt_last = 4'b0010;
        exp_evt.push_back(EV_DONE);
        step();
`else
        for (int k = 0; k < 20; k++) begin
            step();
            if (k % 5 == 4) begin
                check("t6_held", 32'(grant), 32'b0001);
                check("t6_no_timeout", 32'(timeout_err), 32'd0);
            end
        end
        pkt_vld = 4'b0001; pkt_last = 4'b0001;
        exp_evt.push_back(EV_DONE);
        step();
`endif
        bus_sel = '0; pkt_vld = '0; pkt_last = '0;
        repeat (3) step();
        check("sb_grant_drained", 32'(exp_grant.size()), 32'd0);
        check("sb_evt_drained", 32'(exp_evt.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
